// File: rtl/comparator_arbiter.sv
// Round-robin arbiter feeding one shared signed less-than comparator, with a
// single-entry output register (EMPTY/FULL) and a saturating transfer counter.

// Structural signed less-than: a one-bit sign extension makes a-b exact for
// every pair, including opposite-sign extremes, so the sign of the difference
// is the result.
module signed_lt #(
   parameter int N = 32
) (
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   output logic                lt
);
   logic [N:0] diff;

   assign diff = {a[N-1], a} - {b[N-1], b};
   assign lt   = diff[N];
endmodule

module comparator_arbiter #(
   parameter  int N  = 32,
   parameter  int R  = 4,
   localparam int IW = $clog2(R)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [R-1:0]    req_valid,
   input  logic [R*N-1:0]  req_a,
   input  logic [R*N-1:0]  req_b,
   output logic [R-1:0]    req_ready,
   output logic            rsp_valid,
   output logic            rsp_lt,
   output logic [IW-1:0]   rsp_id,
   input  logic            rsp_ready,
   output logic [15:0]     cmp_count
);

   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      grant_id;
   logic [IW-1:0]      cand;
   logic [R-1:0]       grant_vec;
   logic               found;
   logic               armed;
   logic               grant_ok;
   logic               transfer;
   logic               lt;
   logic signed [N-1:0] sel_a;
   logic signed [N-1:0] sel_b;

   // Counter saturates instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      grant_vec = '0;
      grant_id  = '0;
      cand      = '0;
      found     = 1'b0;
      for (int k = 1; k <= R; k++) begin
         cand = IW'((int'(last_grant) + k) % R);
         if (!found && req_valid[cand]) begin
            found           = 1'b1;
            grant_id        = cand;
            grant_vec[cand] = 1'b1;
         end
      end
   end

   // A grant needs an empty slot or a slot being drained this cycle; armed
   // blocks any transfer in the cycle reset is released.
   assign grant_ok  = armed & (~rsp_valid | rsp_ready);
   assign req_ready = grant_ok ? grant_vec : '0;
   assign transfer  = grant_ok & found;

   // Operand mux for the granted requester; unregistered so the result lands one edge later.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < R; i++) begin
         if (grant_id == IW'(i)) begin
            sel_a = req_a[i*N +: N];
            sel_b = req_b[i*N +: N];
         end
      end
   end

   signed_lt #(.N(N)) u_lt (
      .a  (sel_a),
      .b  (sel_b),
      .lt (lt)
   );

   // Output slot, arbitration history and transfer counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_lt     <= 1'b0;
         rsp_id     <= '0;
         last_grant <= IW'(R - 1);
         cmp_count  <= '0;
      end else begin
         armed <= 1'b1;
         if (transfer) begin
            rsp_valid  <= 1'b1;
            rsp_lt     <= lt;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            cmp_count  <= sat_inc(cmp_count);
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_lt    <= 1'b0;
            rsp_id    <= '0;
         end
      end
   end

endmodule

// File: doc/comparator_arbiter.md
COMPARATOR_ARBITER -- requirements
Module: comparator_arbiter

Interface
REQ-001 Parameter N, default 32: operand width in bits, signed two's complement.
REQ-002 Parameter R, default 4: number of requesters; legal range 2..8.
REQ-003 Derived value IW = $clog2(R): requester-ID width.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  R  bit i high = requester i offers an operand pair.
REQ-007 req_a  input  R*N  operand a for requester i, in bits [i*N +: N].
REQ-008 req_b  input  R*N  operand b for requester i, in bits [i*N +: N].
REQ-009 req_ready  output  R  one-hot or zero; bit i high = requester i accepted this cycle.
REQ-010 rsp_valid  output  1  a result is held in the output register.
REQ-011 rsp_lt  output  1  result: 1 iff signed a < signed b.
REQ-012 rsp_id  output  IW  index of the requester that owns the result.
REQ-013 rsp_ready  input  1  downstream accepts the result this cycle.
REQ-014 cmp_count  output  16  total accepted comparisons since reset.

Function
REQ-015 The block SHALL contain exactly one instance of the team's structural signed less-than comparator, shared by all requesters.
REQ-016 The comparator result SHALL be correct for every signed pair, including opposite-sign extremes (e.g., -2^(N-1) vs 2^(N-1)-1).
REQ-017 Output state SHALL be EMPTY (rsp_valid=0) or FULL (rsp_valid=1); no other state exists.
REQ-018 A grant SHALL be possible only when state is EMPTY, or FULL with rsp_ready=1 in the same cycle (drain-and-refill).
REQ-019 When a grant is possible and any req_valid bit is set, exactly one req_ready bit SHALL be driven high, combinationally, in that cycle.
REQ-020 req_ready SHALL never be high for a requester whose req_valid is low.
REQ-021 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod R, wrapping; the first valid requester wins.
REQ-022 last_grant SHALL update only on an actual transfer (req_valid & req_ready).
REQ-023 On a transfer from requester i at edge k, after edge k: rsp_valid=1, rsp_id=i, rsp_lt=(a_i < b_i); latency is 1 cycle.
REQ-024 The selected operands SHALL be muxed into the comparator combinationally; only the 1-bit result and the ID are registered.
REQ-025 While FULL and rsp_ready=0, rsp_valid, rsp_lt and rsp_id SHALL hold stable, and req_ready SHALL be all zero.
REQ-026 FULL with rsp_ready=1 and no valid request SHALL go EMPTY on the next edge.
REQ-027 FULL with rsp_ready=1 and a valid request SHALL stay FULL with the new result: back-to-back throughput is one per cycle.
REQ-028 When rsp_valid=0, rsp_lt and rsp_id SHALL be 0.
REQ-029 cmp_count SHALL increment by 1 on each transfer and saturate at 16'hFFFF.
REQ-030 A requester SHALL keep req_a and req_b stable while req_valid is high until accepted; the block does not check this.

Reset
REQ-031 Reset SHALL take effect immediately while rst_n=0, independent of clk.
REQ-032 While rst_n=0: rsp_valid=0, rsp_lt=0, rsp_id=0, cmp_count=0, req_ready all zero, last_grant=R-1 (so requester 0 has first priority).
REQ-033 Reset mid-operation SHALL discard any held result; the first transfer after release SHALL follow REQ-032 priority.
REQ-034 No transfer SHALL occur in the cycle in which rst_n deasserts.

Verification
REQ-035 Single request: R=4, N=32, only req 2 valid with a=-5, b=3, rsp_ready=1 -> req_ready=4'b0100; next cycle rsp_valid=1, rsp_id=2, rsp_lt=1; cmp_count=1.
REQ-036 Overflow extremes via req 0: a=32'h80000000, b=32'h7FFFFFFF -> rsp_lt=1. Swapped operands -> rsp_lt=0. Equal operands (a=b=7) -> rsp_lt=0.
REQ-037 All 4 requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid stays 1.
REQ-038 Backpressure: hold rsp_ready=0 for 3 cycles while req 1 and req 3 are valid -> result stable, req_ready=0; on the cycle rsp_ready=1, the next grant goes to round-robin winner.
REQ-039 Assert rst_n=0 asynchronously between edges while FULL -> rsp_valid and cmp_count drop to 0 before the next edge; after release, req 0 wins a full-contention round.
REQ-040 Saturation: force 65,537 transfers -> cmp_count reads 16'hFFFF and holds.
